block_max_scheduler: RTL and testbench



---
 rtl/block_max_scheduler.sv | 125 ++++++++++++
 tb/tb_block_max_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_max_scheduler.sv
// rtl/block_max_scheduler.sv - buffers one block of beats, then replays it with the block's absolute maximum
module block_max_scheduler #(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int MAX_BEATS      = 8,
    parameter int MAX_NUM_WIDTH  = IN_WIDTH,
    parameter int BEAT_CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [BEAT_CNT_WIDTH-1:0]            cfg_beats,
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]     data_in,
    input  logic                                 data_in_valid,
    output logic                                 data_in_ready,
    output logic [IN_SIZE-1:0][IN_WIDTH-1:0]     data_out,
    output logic                                 data_out_valid,
    input  logic                                 data_out_ready,
    output logic                                 data_out_last,
    output logic [MAX_NUM_WIDTH-1:0]             max_num
);

    localparam int ADDR_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BEAT_CNT_WIDTH-1:0] LEN_MAX  = BEAT_CNT_WIDTH'(MAX_BEATS);
    localparam logic [BEAT_CNT_WIDTH-1:0] ONE      = BEAT_CNT_WIDTH'(1);
    localparam logic [IN_WIDTH-1:0]       MOST_NEG = {1'b1, {(IN_WIDTH-1){1'b0}}};
    localparam logic [IN_WIDTH-1:0]       MOST_POS = {1'b0, {(IN_WIDTH-1){1'b1}}};

    typedef enum logic {COLLECT, EMIT} state_t;
    state_t state_q, state_d;

    logic [IN_SIZE-1:0][IN_WIDTH-1:0] buffer [MAX_BEATS];
    logic [BEAT_CNT_WIDTH-1:0] wr_cnt, rd_cnt, len_q, cfg_len, len_cur;
    logic [IN_WIDTH-1:0]       run_max, beat_max, upd_max;
    logic                      accept, emit_hs, first_beat, last_in, last_out;

    // Magnitude on IN_WIDTH bits; the most negative code saturates instead of wrapping.
    function automatic logic [IN_WIDTH-1:0] abs_sat(input logic [IN_WIDTH-1:0] x);
        if (x == MOST_NEG)
            return MOST_POS;
        else if (x[IN_WIDTH-1])
            return -x;
        else
            return x;
    endfunction

    always_comb begin
        beat_max = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (abs_sat(data_in[i]) > beat_max)
                beat_max = abs_sat(data_in[i]);
        end
    end

    // The block length is taken live from cfg_beats on the first beat, from len_q afterwards.
    always_comb begin
        first_beat = (wr_cnt == '0);
        if (cfg_beats == '0)
            cfg_len = ONE;
        else if (cfg_beats > LEN_MAX)
            cfg_len = LEN_MAX;
        else
            cfg_len = cfg_beats;
        len_cur  = first_beat ? cfg_len : len_q;
        upd_max  = (first_beat || (beat_max > run_max)) ? beat_max : run_max;
        last_in  = (wr_cnt == len_cur - ONE);
        last_out = (rd_cnt == len_q - ONE);
    end

    always_comb begin
        state_d        = state_q;
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        data_out_last  = 1'b0;
        case (state_q)
            COLLECT: begin
                data_in_ready = 1'b1;
                if (data_in_valid && last_in)
                    state_d = EMIT;
            end
            EMIT: begin
                data_out_valid = 1'b1;
                data_out_last  = last_out;
                if (data_out_ready && last_out)
                    state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    assign accept   = data_in_valid && data_in_ready;
    assign emit_hs  = data_out_valid && data_out_ready;
    assign data_out = buffer[rd_cnt[ADDR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            len_q   <= ONE;
            run_max <= '0;
            max_num <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (first_beat)
                    len_q <= len_cur;
                run_max <= upd_max;
                if (last_in) begin
                    wr_cnt  <= '0;
                    max_num <= MAX_NUM_WIDTH'(upd_max);
                end else begin
                    wr_cnt <= wr_cnt + ONE;
                end
            end
            if (emit_hs)
                rd_cnt <= last_out ? '0 : rd_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            buffer[wr_cnt[ADDR_W-1:0]] <= data_in;
    end

endmodule

// File: tb/tb_block_max_scheduler.sv
// tb/tb_block_max_scheduler.sv - scoreboard bench for block_max_scheduler with a per-block reference model
module tb_block_max_scheduler;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int MB = 8;
    localparam int CW = 4;

    typedef logic [N-1:0][W-1:0] beat_t;
    typedef struct {
        beat_t        data;
        logic         last;
        logic [W-1:0] mx;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [CW-1:0] cfg_beats;
    beat_t         data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    beat_t         data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          data_out_last;
    logic [W-1:0]  max_num;

    block_max_scheduler #(
        .IN_WIDTH(W), .IN_SIZE(N), .MAX_BEATS(MB), .MAX_NUM_WIDTH(W), .BEAT_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_beats(cfg_beats),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out_last(data_out_last), .max_num(max_num)
    );

    exp_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    last_max = 0;
    int    ready_mode = 0;
    bit    use_dir = 0;
    beat_t dir [MB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s actual=timeout required=progress", name);
    endtask

    function automatic int mag(input logic [W-1:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_elem();
        case ($urandom_range(7))
            0: return 16'h8000;
            1: return 16'h7fff;
            2: return 16'hffff;
            default: return W'($urandom);
        endcase
    endfunction

    // Downstream ready: 0 = always, 1 = 1,0,0 repeating, 2 = random, 3 = never.
    initial begin
        int k;
        k = 0;
        data_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: data_out_ready = 1'b1;
                1: data_out_ready = (k % 3 == 0);
                2: data_out_ready = 1'($urandom_range(1));
                default: data_out_ready = 1'b0;
            endcase
            k++;
        end
    end

    // A block's beats enter the scoreboard only once the whole block is accepted, so a
    // non-empty queue is exactly the window in which the DUT must be emitting.
    initial begin
        logic  pv, phs, pl;
        beat_t pd;
        exp_t  e;
        pv = 0; phs = 0; pl = 0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0;
                continue;
            end
            chk("in_ready", data_in_ready, exp_q.size() == 0);
            chk("out_valid", data_out_valid, exp_q.size() != 0);
            if (pv && !phs) begin
                chk("hold_data", data_out, pd);
                chk("hold_last", data_out_last, pl);
            end
            if (data_out_valid && exp_q.size() != 0) begin
                chk("max_emit", max_num, exp_q[0].mx);
                if (data_out_ready) begin
                    e = exp_q.pop_front();
                    chk("data", data_out, e.data);
                    chk("last", data_out_last, e.last);
                    if (e.last) last_max = int'(e.mx);
                end
            end else begin
                chk("max_hold", max_num, W'(last_max));
                chk("last_idle", data_out_last, 1'b0);
            end
            pv  = data_out_valid;
            phs = data_out_valid && data_out_ready;
            pd  = data_out;
            pl  = data_out_last;
        end
    end

    // stop < 0 sends the whole block; otherwise only the first stop beats, never scoreboarded.
    task automatic send_block(input int cfg, input int vpct, input bit chg, input int stop);
        int    len, m, tmo;
        bit    acc;
        beat_t b [MB];
        exp_t  e;
        exp_t  blk[$];
        len = (cfg == 0) ? 1 : ((cfg > MB) ? MB : cfg);
        m = 0;
        for (int i = 0; i < len; i++) begin
            if (use_dir) b[i] = dir[i];
            else for (int j = 0; j < N; j++) b[i][j] = rand_elem();
            for (int j = 0; j < N; j++) if (mag(b[i][j]) > m) m = mag(b[i][j]);
        end
        for (int i = 0; i < len; i++) begin
            if (stop >= 0 && i >= stop) begin
                data_in_valid = 1'b0;
                return;
            end
            data_in   = b[i];
            cfg_beats = (i == 0 || !chg) ? CW'(cfg) : CW'($urandom);
            acc = 0;
            tmo = 0;
            while (!acc) begin
                data_in_valid = ($urandom_range(99) < vpct);
                @(negedge clk);
                acc = data_in_valid && data_in_ready;
                @(posedge clk);
                #1;
                tmo++;
                if (tmo > 500) begin
                    timeout_fail("input_accept");
                    data_in_valid = 1'b0;
                    return;
                end
            end
            e.data = b[i];
            e.last = (i == len - 1);
            e.mx   = W'(m);
            blk.push_back(e);
        end
        data_in_valid = 1'b0;
        chk("first_out_latency", data_out_valid, 1'b1);
        foreach (blk[i]) exp_q.push_back(blk[i]);
    endtask

    task automatic wait_drain();
        int tmo;
        tmo = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            tmo++;
            if (tmo > 1000) begin
                timeout_fail("drain");
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", data_in_ready, 1'b1);
        chk("rst_out_valid", data_out_valid, 1'b0);
        chk("rst_out_last", data_out_last, 1'b0);
        chk("rst_max_num", max_num, '0);
        exp_q.delete();
        last_max = 0;
        data_in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cfg_beats = '0;
        data_in = '0;
        data_in_valid = 1'b0;
        #2;
        chk("reset_in_ready", data_in_ready, 1'b1);
        chk("reset_out_valid", data_out_valid, 1'b0);
        chk("reset_out_last", data_out_last, 1'b0);
        chk("reset_max_num", max_num, '0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        ready_mode = 0;
        use_dir = 1;
        dir[0][0] = 16'd1; dir[0][1] = 16'd5; dir[0][2] = 16'd3; dir[0][3] = 16'd2;
        dir[1][0] = 16'd4; dir[1][1] = 16'd7; dir[1][2] = 16'd0; dir[1][3] = 16'd6;
        send_block(2, 100, 0, -1);
        wait_drain();
        chk("max_positive", max_num, 16'd7);

        dir[0][0] = 16'hfffd; dir[0][1] = 16'h8000; dir[0][2] = 16'd2; dir[0][3] = 16'd1;
        send_block(1, 100, 0, -1);
        wait_drain();
        chk("max_saturated", max_num, 16'h7fff);
        dir[0][0] = 16'hfff7; dir[0][1] = 16'd4; dir[0][2] = 16'd0; dir[0][3] = 16'd1;
        send_block(1, 100, 0, -1);
        wait_drain();
        chk("max_no_carry", max_num, 16'd9);

        use_dir = 0;
        ready_mode = 1;
        send_block(4, 100, 0, -1);
        wait_drain();

        ready_mode = 2;
        send_block(0, 100, 0, -1);
        send_block(15, 100, 0, -1);
        send_block(3, 100, 1, -1);
        send_block(8, 70, 1, -1);
        wait_drain();

        send_block(4, 100, 0, 2);
        do_reset();
        ready_mode = 0;
        send_block(4, 100, 0, -1);
        wait_drain();

        ready_mode = 3;
        send_block(4, 100, 0, -1);
        repeat (3) @(posedge clk);
        do_reset();
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        send_block(4, 100, 0, -1);
        wait_drain();

        ready_mode = 2;
        for (int n = 0; n < 100; n++)
            send_block($urandom_range(15), $urandom_range(100, 30), 1'($urandom_range(1)), -1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
